// File: rtl/mpc_dot_pkg.sv
// Shared constants and elaboration helpers for the MPC dot-product accumulator.
// Optional output saturation is selected with the MPC_DOT_SAT_EN macro.
package mpc_dot_pkg;

    localparam int PROD_WIDTH_DEF = 28;
    localparam int ACC_WIDTH_DEF  = 36;
    localparam int OUT_WIDTH_DEF  = 21;
    localparam int ROW_LEN_DEF    = 8;
    localparam int NUM_ROWS_DEF   = 16;
    localparam int FRAC_SHIFT_DEF = 6;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Counter width that stays legal when the count range is a single value.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic longint rnd_const(input int shift);
        return 64'sd1 <<< (shift - 1);
    endfunction

    localparam longint RND_CONST = rnd_const(FRAC_SHIFT_DEF);

    function automatic longint sat_max(input int out_width);
        return (64'sd1 <<< (out_width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int out_width);
        return -(64'sd1 <<< (out_width - 1));
    endfunction

endpackage

// File: rtl/mpc_dot_round_sat.sv
// Round-half-up, arithmetic right shift and narrowing of a dot-product sum.
// With MPC_DOT_SAT_EN defined the result clips to the output range and flags it.
module mpc_dot_round_sat
    import mpc_dot_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
    input  logic signed [ACC_WIDTH-1:0] sum,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        sat
);

    // One guard bit so the rounding constant cannot overflow a full-scale sum.
    localparam int EXT_W = ACC_WIDTH + 1;
    localparam logic signed [EXT_W-1:0] RND = EXT_W'(rnd_const(FRAC_SHIFT));

    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] r;

    assign biased = EXT_W'(sum) + RND;
    assign r      = biased >>> FRAC_SHIFT;

`ifdef MPC_DOT_SAT_EN
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(sat_max(OUT_WIDTH));
    localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(sat_min(OUT_WIDTH));

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        dout = r[OUT_WIDTH-1:0];
        sat  = 1'b0;
        if (r > MAX_V) begin
            dout = OUT_WIDTH'(sat_max(OUT_WIDTH));
            sat  = 1'b1;
        end else if (r < MIN_V) begin
            dout = OUT_WIDTH'(sat_min(OUT_WIDTH));
            sat  = 1'b1;
        end
    end
`else
    logic unused_r_hi;

    assign dout        = r[OUT_WIDTH-1:0];
    assign sat         = 1'b0;
    assign unused_r_hi = ^r[EXT_W-1:OUT_WIDTH];
`endif

endmodule

// File: rtl/mpc_dot_accum.sv
// Accumulates ROW_LEN signed products per row and emits the rounded result with its row index.
// Saturating output is enabled by defining MPC_DOT_SAT_EN.
module mpc_dot_accum
    import mpc_dot_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int ROW_LEN    = ROW_LEN_DEF,
    parameter int NUM_ROWS   = NUM_ROWS_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ce,
    input  logic                              clr,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [PROD_WIDTH-1:0]      din,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [OUT_WIDTH-1:0]       dout,
    output logic [idx_width(NUM_ROWS)-1:0]    out_row,
    output logic                              dout_sat
);

    localparam int TERM_W = idx_width(ROW_LEN);
    localparam int ROW_W  = idx_width(NUM_ROWS);

    if (ACC_WIDTH < PROD_WIDTH + clog2(ROW_LEN)) begin : g_acc_width_check
        $error("mpc_dot_accum: ACC_WIDTH too narrow for PROD_WIDTH and ROW_LEN");
    end

    logic [TERM_W-1:0]           term_cnt;
    logic [ROW_W-1:0]            row_cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic signed [OUT_WIDTH-1:0] rs_dout;
    logic                        rs_sat;
    logic                        take;
    logic                        last_term;
    logic                        unload;

    assign in_ready  = !out_valid || out_ready;
    assign take      = ce && in_valid && in_ready && !clr;
    assign last_term = (term_cnt == TERM_W'(ROW_LEN - 1));
    assign unload    = ce && out_valid && out_ready;

    // The first term of a row restarts the sum instead of adding to stale data.
    always_comb begin
        sum_next = ACC_WIDTH'(din);
        if (term_cnt != '0) sum_next = acc + ACC_WIDTH'(din);
    end

    mpc_dot_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .FRAC_SHIFT(FRAC_SHIFT)
    ) u_round_sat (
        .sum (sum_next),
        .dout(rs_dout),
        .sat (rs_sat)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            term_cnt <= '0;
            row_cnt  <= '0;
        end else if (ce) begin
            if (clr) begin
                term_cnt <= '0;
                row_cnt  <= '0;
            end else if (take) begin
                acc <= sum_next;
                if (last_term) begin
                    term_cnt <= '0;
                    row_cnt  <= (row_cnt == ROW_W'(NUM_ROWS - 1)) ? '0 : row_cnt + ROW_W'(1);
                end else begin
                    term_cnt <= term_cnt + TERM_W'(1);
                end
            end
        end
    end

    // Output holding stage: a new result wins over a simultaneous transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_row   <= '0;
            dout_sat  <= 1'b0;
        end else if (ce) begin
            if (take && last_term) begin
                out_valid <= 1'b1;
                dout      <= rs_dout;
                out_row   <= row_cnt;
                dout_sat  <= rs_sat;
            end else if (unload) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
